// File: rtl/friction_engine.sv
// friction_engine
//   Once per video frame, walks the five balls through one shared datapath,
//   clamps their speeds, applies a one-LSB decay every FRIC_PERIOD frames and
//   commits all ten decayed speeds plus per-ball status in a single cycle.
//   Also flags the end of a round once the table has been at rest for
//   SETTLE_FRAMES consecutive frames after a shot.
//
// Ports
//   clk, reset_n                 system clock, synchronous active-low reset
//   frame_start                  one-cycle frame pulse (synchronised vsync)
//   new_xspeedN/new_yspeedN      current ball speeds, 11-bit signed (N=1..5)
//   ballN_pocketed               ball is off the table
//   xspeedN_prev/yspeedN_prev    friction-reduced speeds, registered
//   fric_stateN                  0 STOPPED, 1 ROLLING, 2 DECAYED, 4 POCKETED
//   done_fric_all                round-over, high for one frame interval
//   busy                         scan in progress
//   overrun                      sticky: frame_start seen while busy
module friction_engine #(
  parameter int FRIC_PERIOD   = 4,
  parameter int SETTLE_FRAMES = 2,
  parameter int MAX_SPEED     = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic signed [10:0] new_xspeed1, new_yspeed1,
  input  logic signed [10:0] new_xspeed2, new_yspeed2,
  input  logic signed [10:0] new_xspeed3, new_yspeed3,
  input  logic signed [10:0] new_xspeed4, new_yspeed4,
  input  logic signed [10:0] new_xspeed5, new_yspeed5,
  input  logic               ball1_pocketed, ball2_pocketed, ball3_pocketed,
  input  logic               ball4_pocketed, ball5_pocketed,
  output logic signed [10:0] xspeed1_prev, yspeed1_prev,
  output logic signed [10:0] xspeed2_prev, yspeed2_prev,
  output logic signed [10:0] xspeed3_prev, yspeed3_prev,
  output logic signed [10:0] xspeed4_prev, yspeed4_prev,
  output logic signed [10:0] xspeed5_prev, yspeed5_prev,
  output logic [2:0]         fric_state1, fric_state2, fric_state3,
  output logic [2:0]         fric_state4, fric_state5,
  output logic               done_fric_all,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_SUMMARY} state_t;
  typedef enum logic [2:0] {
    FS_STOPPED  = 3'd0,
    FS_ROLLING  = 3'd1,
    FS_DECAYED  = 3'd2,
    FS_POCKETED = 3'd4
  } fric_t;

  localparam logic signed [10:0] VMAX      = 11'(MAX_SPEED);
  localparam logic [3:0]         LAST_CNT  = 4'(FRIC_PERIOD - 1);
  localparam logic [3:0]         SETTLE_TH = 4'(SETTLE_FRAMES);

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v);
    if (v > VMAX)       return VMAX;
    else if (v < -VMAX) return -VMAX;
    else                return v;
  endfunction

  // One LSB toward zero; zero stays zero.
  function automatic logic signed [10:0] decay(input logic signed [10:0] v);
    if (v > 11'sd0)      return v - 11'sd1;
    else if (v < 11'sd0) return v + 11'sd1;
    else                 return v;
  endfunction

  // Input fan-in as arrays so the shared datapath can index by ball.
  logic signed [10:0] in_x [5];
  logic signed [10:0] in_y [5];
  logic [4:0]         in_pock;

  assign in_x[0] = new_xspeed1;  assign in_y[0] = new_yspeed1;
  assign in_x[1] = new_xspeed2;  assign in_y[1] = new_yspeed2;
  assign in_x[2] = new_xspeed3;  assign in_y[2] = new_yspeed3;
  assign in_x[3] = new_xspeed4;  assign in_y[3] = new_yspeed4;
  assign in_x[4] = new_xspeed5;  assign in_y[4] = new_yspeed5;
  assign in_pock = {ball5_pocketed, ball4_pocketed, ball3_pocketed,
                    ball2_pocketed, ball1_pocketed};

  state_t             state, state_next;
  logic [2:0]         idx;
  logic signed [10:0] ld_x, ld_y;
  logic               ld_pock;
  logic signed [10:0] calc_x, calc_y, calc_x_d, calc_y_d;
  logic [3:0]         calc_cnt, calc_cnt_d;
  fric_t              calc_st, calc_st_d;
  logic [3:0]         cnt   [5];
  logic signed [10:0] sh_x  [5];
  logic signed [10:0] sh_y  [5];
  fric_t              sh_st [5];
  logic signed [10:0] out_x [5];
  logic signed [10:0] out_y [5];
  fric_t              out_st[5];
  logic [2:0]         settle;
  logic [3:0]         settle_inc;
  logic               armed;
  logic               all_stopped;

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (frame_start) state_next = S_LOAD;
      S_LOAD:    state_next = S_CALC;
      S_CALC:    state_next = S_WRITE;
      S_WRITE:   state_next = (idx == 3'd4) ? S_SUMMARY : S_LOAD;
      S_SUMMARY: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Per-ball friction rule; pocketed wins over stopped, stopped over decay.
  always_comb begin
    calc_x_d   = ld_x;
    calc_y_d   = ld_y;
    calc_cnt_d = cnt[idx] + 4'd1;
    calc_st_d  = FS_ROLLING;
    if (ld_pock) begin
      calc_x_d   = '0;
      calc_y_d   = '0;
      calc_cnt_d = '0;
      calc_st_d  = FS_POCKETED;
    end else if (ld_x == 11'sd0 && ld_y == 11'sd0) begin
      calc_cnt_d = '0;
      calc_st_d  = FS_STOPPED;
    end else if (cnt[idx] == LAST_CNT) begin
      calc_x_d   = decay(ld_x);
      calc_y_d   = decay(ld_y);
      calc_cnt_d = '0;
      calc_st_d  = FS_DECAYED;
    end
  end

  // A ball counts as moving only when ROLLING or DECAYED, i.e. it was on
  // the table with a nonzero clamped speed this scan.
  always_comb begin
    all_stopped = 1'b1;
    for (int b = 0; b < 5; b++)
      if (sh_st[b] == FS_ROLLING || sh_st[b] == FS_DECAYED) all_stopped = 1'b0;
  end

  assign settle_inc = {1'b0, settle} + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the small per-ball arrays are reset explicitly; a reset must
      // leave no stale counter or shadow value to leak into the next frame.
      for (int b = 0; b < 5; b++) begin
        cnt[b]    <= '0;
        sh_x[b]   <= '0;
        sh_y[b]   <= '0;
        sh_st[b]  <= FS_STOPPED;
        out_x[b]  <= '0;
        out_y[b]  <= '0;
        out_st[b] <= FS_STOPPED;
      end
      idx           <= '0;
      ld_x          <= '0;
      ld_y          <= '0;
      ld_pock       <= 1'b0;
      calc_x        <= '0;
      calc_y        <= '0;
      calc_cnt      <= '0;
      calc_st       <= FS_STOPPED;
      settle        <= '0;
      armed         <= 1'b0;
      done_fric_all <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (frame_start && state != S_IDLE) overrun <= 1'b1;
      unique case (state)
        S_IDLE: if (frame_start) idx <= '0;
        S_LOAD: begin
          ld_x    <= clamp(in_x[idx]);
          ld_y    <= clamp(in_y[idx]);
          ld_pock <= in_pock[idx];
        end
        S_CALC: begin
          calc_x   <= calc_x_d;
          calc_y   <= calc_y_d;
          calc_cnt <= calc_cnt_d;
          calc_st  <= calc_st_d;
        end
        S_WRITE: begin
          sh_x[idx]  <= calc_x;
          sh_y[idx]  <= calc_y;
          sh_st[idx] <= calc_st;
          cnt[idx]   <= calc_cnt;
          if (idx != 3'd4) idx <= idx + 3'd1;
        end
        S_SUMMARY: begin
          for (int b = 0; b < 5; b++) begin
            out_x[b]  <= sh_x[b];
            out_y[b]  <= sh_y[b];
            out_st[b] <= sh_st[b];
          end
          done_fric_all <= 1'b0;
          armed         <= armed | ~all_stopped;
          if (all_stopped) settle <= (settle == 3'd7) ? 3'd7 : settle + 3'd1;
          else             settle <= '0;
          // Round over only once the table is at rest after a shot.
          if (all_stopped && armed && settle_inc >= SETTLE_TH) begin
            done_fric_all <= 1'b1;
            armed         <= 1'b0;
            settle        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign xspeed1_prev = out_x[0];  assign yspeed1_prev = out_y[0];
  assign xspeed2_prev = out_x[1];  assign yspeed2_prev = out_y[1];
  assign xspeed3_prev = out_x[2];  assign yspeed3_prev = out_y[2];
  assign xspeed4_prev = out_x[3];  assign yspeed4_prev = out_y[3];
  assign xspeed5_prev = out_x[4];  assign yspeed5_prev = out_y[4];
  assign fric_state1  = out_st[0];
  assign fric_state2  = out_st[1];
  assign fric_state3  = out_st[2];
  assign fric_state4  = out_st[3];
  assign fric_state5  = out_st[4];

endmodule

// File: doc/friction_engine.md
# friction_engine

Per-frame friction and stop-detection unit that closes the speed loop around the ball position updater. Once per video frame it scans all five balls' current speeds (`new_xspeedN`/`new_yspeedN`), applies one-LSB magnitude decay on a per-ball frame schedule, and returns the decayed speeds as `xspeedN_prev`/`yspeedN_prev`. It also raises `done_fric_all` when the table has come to rest after a shot. It runs on the system clock and serialises the five balls through one shared datapath. All five results commit atomically, so the position updater never samples a mix of old and new speeds.

## Interface
- `FRIC_PERIOD`, 4: frames between successive one-LSB decays of a moving ball (legal range 1..15).
- `SETTLE_FRAMES`, 2: consecutive all-stopped frames required before `done_fric_all` (legal range 1..7).
- `MAX_SPEED`, 15: symmetric clamp applied to input speeds.

Ports:
- `clk` in 1: system clock (65 MHz).
- `reset_n` in 1: synchronous, active-low reset.
- `frame_start` in 1: one-`clk` pulse, synchronised rising edge of vsync.
- `new_xspeedN`, `new_yspeedN` (N=1..5) in 11 signed: current ball speeds.
- `ballN_pocketed` (N=1..5) in 1: ball is off the table.
- `xspeedN_prev`, `yspeedN_prev` (N=1..5) out 11 signed: friction-reduced speeds, registered.
- `fric_stateN` (N=1..5) out 3: per-ball status.
  - 0: STOPPED
  - 1: ROLLING
  - 2: DECAYED (decremented this frame)
  - 4: POCKETED
- `done_fric_all` out 1: round-over level.
- `busy` out 1: scan in progress.
- `overrun` out 1: sticky flag; set when `frame_start` arrives while busy.

## Operation
- FSM states: IDLE, LOAD, CALC, WRITE, SUMMARY.
- IDLE → LOAD on `frame_start`, with idx=0.
- LOAD: register the clamped speeds and the pocket bit of ball idx.
- CALC: compute the next speed and counter value.
- WRITE: store the results to shadow registers. If idx<4, increment idx and go to LOAD; otherwise go to SUMMARY.
- SUMMARY: copy all shadow registers to the outputs, update settle/arm logic, then return to IDLE.
- Clamp: v>MAX_SPEED → MAX_SPEED; v<−MAX_SPEED → −MAX_SPEED. This includes −1024.
- Per-ball 4-bit counter `cnt`:
  - Ball pocketed: outputs 0, `cnt`←0, state POCKETED.
  - Both clamped speeds are 0: outputs 0, `cnt`←0, state STOPPED.
  - `cnt`==FRIC_PERIOD−1: each nonzero component moves one LSB toward 0 (a zero component stays 0), `cnt`←0, state DECAYED.
  - Otherwise: outputs equal the clamped inputs, `cnt`←`cnt`+1, state ROLLING.
- Arm/settle logic in SUMMARY:
  - `armed` is set if any non-pocketed ball had a nonzero clamped input this scan.
  - If every ball is STOPPED or POCKETED, `settle` increments, saturating at 7. Otherwise `settle`←0.
  - If `armed` and `settle`+1 ≥ SETTLE_FRAMES: `done_fric_all`←1, `armed`←0, `settle`←0.
  - If `done_fric_all` was already 1, it is cleared in this SUMMARY. `done_fric_all` is therefore high for exactly one frame interval.
- `frame_start` while not in IDLE is ignored and sets `overrun`. `overrun` is cleared only by reset.
- All arithmetic is 11-bit signed; no result can overflow after the clamp.

## Timing
- Take `frame_start` high in cycle 0. Then:
  - Ball N is processed in cycles 3(N−1)+1..3(N−1)+3.
  - SUMMARY occupies cycle 16.
  - New outputs, `fric_stateN` and `done_fric_all` are visible from cycle 17.
  - `busy` is high in cycles 1..16.
- Outputs are stable for the entire remainder of the frame. At 65 MHz, 17 cycles is far shorter than the blanking interval.
- Reset values (any state, including mid-scan, with the scan abandoned):
  - all `xspeedN_prev`/`yspeedN_prev` = 0
  - `fric_stateN` = 0
  - `cnt`, `settle`, `armed` = 0
  - `done_fric_all`, `busy`, `overrun` = 0
  - FSM in IDLE
- The first `frame_start` after reset is serviced normally.

## Test plan
- Decay schedule: ball 1 held at x=+5, y=−3, FRIC_PERIOD=4, one pulse per frame → outputs are (+5,−3) with ROLLING for 3 frames, then (+4,−2) with DECAYED on frame 4; `cnt` restarts.
- Clamp: x=−1024, y=+40 → outputs (−15,+15) at cycle 17.
- Pocketing: ball 3 moving at (+7,0) with `ball3_pocketed`=1 → (0,0), `fric_state3`=4; the other balls are unaffected.
- Round end: one frame with ball 1 at (+1,0), then all-zero inputs with SETTLE_FRAMES=2 → `done_fric_all` high after the second all-stopped SUMMARY for one frame only. An all-zero table without a preceding motion never asserts it.
- Overrun: second `frame_start` at cycle 8 → ignored, `overrun`=1, outputs still commit at cycle 17.
- Reset mid-scan: `reset_n`=0 at cycle 10 → cycle 11 shows all outputs 0, `busy`=0, IDLE. The next pulse completes normally.
